// File: rtl/magnetron_scheduler.sv
// Duty-cycle scheduler for magnetron, fan and turntable with door interlock.
// Optional energy counter output enabled by defining MAGSCHED_ENERGY_EN.
module magnetron_scheduler #(
    parameter int TICK_DIV     = 100,
    parameter int PERIOD_TICKS = 10,
    parameter int COOL_TICKS   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_req,
    input  logic [3:0]  power,
    input  logic        door_closed,
    input  logic        abort,
    output logic        magnetron_on,
    output logic        fan_on,
    output logic        turntable_on,
    output logic        busy,
    output logic        tick
`ifdef MAGSCHED_ENERGY_EN
    ,
    output logic [15:0] energy_ticks
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPINUP,
        ST_HEAT,
        ST_PAUSE,
        ST_COOLDOWN
    } state_t;

    localparam logic [15:0] DIV_LAST   = 16'(TICK_DIV - 1);
    localparam logic [3:0]  PHASE_LAST = 4'(PERIOD_TICKS - 1);
    localparam logic [3:0]  PWR_MAX    = 4'(PERIOD_TICKS);
    localparam logic [3:0]  COOL_LAST  = 4'(COOL_TICKS - 1);

    state_t      state_reg, state_next;
    logic [15:0] div_cnt_reg, div_cnt_next;
    logic [3:0]  phase_reg, phase_next;
    logic [3:0]  pwr_lat_reg, pwr_lat_next;
    logic [3:0]  cool_cnt_reg, cool_cnt_next;
    logic [3:0]  pwr_clamped;

    assign tick        = (div_cnt_reg == DIV_LAST);
    assign pwr_clamped = (power > PWR_MAX) ? PWR_MAX : power;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            div_cnt_reg  <= '0;
            phase_reg    <= '0;
            pwr_lat_reg  <= '0;
            cool_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            div_cnt_reg  <= div_cnt_next;
            phase_reg    <= phase_next;
            pwr_lat_reg  <= pwr_lat_next;
            cool_cnt_reg <= cool_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        div_cnt_next  = tick ? '0 : div_cnt_reg + 16'd1;
        phase_next    = phase_reg;
        pwr_lat_next  = pwr_lat_reg;
        cool_cnt_next = cool_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (run_req && door_closed) begin
                    state_next   = ST_SPINUP;
                    pwr_lat_next = pwr_clamped;
                    phase_next   = '0;
                    div_cnt_next = '0;
                end
            end
            ST_SPINUP, ST_HEAT: begin
                // abort beats door open, which beats run_req drop, which beats tick
                if (abort || (door_closed && !run_req)) begin
                    state_next    = ST_COOLDOWN;
                    div_cnt_next  = '0;
                    cool_cnt_next = '0;
                end else if (!door_closed) begin
                    state_next = ST_PAUSE;
                end else if (tick) begin
                    if (state_reg == ST_SPINUP) begin
                        state_next = ST_HEAT;
                    end else begin
                        phase_next = (phase_reg == PHASE_LAST) ? '0 : phase_reg + 4'd1;
                    end
                end
            end
            ST_PAUSE: begin
                if (abort || !run_req) begin
                    state_next    = ST_COOLDOWN;
                    div_cnt_next  = '0;
                    cool_cnt_next = '0;
                end else if (door_closed) begin
                    // Resume keeps the window phase; only the power level is relatched
                    state_next   = ST_SPINUP;
                    pwr_lat_next = pwr_clamped;
                    div_cnt_next = '0;
                end
            end
            ST_COOLDOWN: begin
                if (tick) begin
                    if (cool_cnt_reg == COOL_LAST) begin
                        state_next = ST_IDLE;
                    end else begin
                        cool_cnt_next = cool_cnt_reg + 4'd1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign magnetron_on = (state_reg == ST_HEAT) && (phase_reg < pwr_lat_reg);
    assign fan_on       = (state_reg != ST_IDLE);
    assign turntable_on = (state_reg == ST_SPINUP) || (state_reg == ST_HEAT);
    assign busy         = (state_reg != ST_IDLE);

`ifdef MAGSCHED_ENERGY_EN
    logic [15:0] energy_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            energy_reg <= '0;
        end else if (state_reg == ST_IDLE && state_next == ST_SPINUP) begin
            energy_reg <= '0;
        end else if (tick && magnetron_on && energy_reg != 16'hFFFF) begin
            energy_reg <= energy_reg + 16'd1;
        end
    end

    assign energy_ticks = energy_reg;
`endif

endmodule
